lsu_mem_master: RTL and testbench

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master_if.sv | 47 ++++
 rtl/lsu_mem_master.sv | 180 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// ============================================================================
// Module      : lsu_mem_master_if
// Description : Core-request and memory-controller signal bundle for the LSU.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface lsu_mem_master_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic [1:0]  req_size_in;
  logic        req_unsigned_in;
  logic        resp_valid_out;
  logic [31:0] resp_data_out;
  logic        resp_err_out;
  logic [31:0] mc_addr_out;
  logic [31:0] mc_write_data_out;
  logic [3:0]  mc_write_byte_en_out;
  logic        cs_out;
  logic        mc_read_en_out;
  logic        mc_write_en_out;
  logic        valid_out;
  logic        ready_in;
  logic        rdata_valid_in;
  logic [31:0] mc_read_data_in;

  modport master (
    input  req_valid_in, req_write_in, req_addr_in, req_wdata_in, req_size_in,
           req_unsigned_in, ready_in, rdata_valid_in, mc_read_data_in,
    output req_ready_out, resp_valid_out, resp_data_out, resp_err_out,
           mc_addr_out, mc_write_data_out, mc_write_byte_en_out, cs_out,
           mc_read_en_out, mc_write_en_out, valid_out
  );

  modport slave (
    output req_valid_in, req_write_in, req_addr_in, req_wdata_in, req_size_in,
           req_unsigned_in, ready_in, rdata_valid_in, mc_read_data_in,
    input  req_ready_out, resp_valid_out, resp_data_out, resp_err_out,
           mc_addr_out, mc_write_data_out, mc_write_byte_en_out, cs_out,
           mc_read_en_out, mc_write_en_out, valid_out
  );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_master.sv
// ============================================================================
// Module      : lsu_mem_master
// Description : Load/store unit bus master: one outstanding access, lane
//               steering, load extension, alignment and timeout errors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_master #(
  parameter logic [31:0] DATA_BASE      = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  lsu_mem_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RDATA = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [4:0] c_tmo_last = 5'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_tmo_cnt;
  logic        r_write;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_handshake;
  logic        w_tmo;
  logic        w_timeout;
  logic        w_capture;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;

  assign w_accept     = bus.req_valid_in & bus.req_ready_out;
  assign w_misaligned = (bus.req_size_in == 2'b11)
                      | ((bus.req_size_in == 2'b01) & bus.req_addr_in[0])
                      | ((bus.req_size_in == 2'b10) & (bus.req_addr_in[1:0] != 2'b00));
  assign w_handshake  = (r_state == S_REQ) & bus.valid_out & bus.ready_in;
  assign w_tmo        = (r_tmo_cnt == c_tmo_last);
  assign w_timeout    = w_tmo & (((r_state == S_REQ) & ~w_handshake)
                               | ((r_state == S_RDATA) & ~bus.rdata_valid_in));
  assign w_capture    = (w_handshake & ~r_write & bus.rdata_valid_in)
                      | ((r_state == S_RDATA) & bus.rdata_valid_in);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.req_wdata_in;
    case (bus.req_size_in)
      2'b00: begin
        w_be    = 4'b0001 << bus.req_addr_in[1:0];
        w_wdata = {4{bus.req_wdata_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << bus.req_addr_in[1:0];
        w_wdata = {2{bus.req_wdata_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend by access size.
  assign w_shifted = r_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load_ext = w_shifted;
    case (r_size)
      2'b00:   w_load_ext = r_unsigned ? {24'h0, w_shifted[7:0]}
                                       : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load_ext = r_unsigned ? {16'h0, w_shifted[15:0]}
                                       : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_misaligned ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (w_handshake)
          w_state_next = (r_write | bus.rdata_valid_in) ? S_RESP : S_RDATA;
        else if (w_tmo)
          w_state_next = S_RESP;
      end
      S_RDATA: begin
        if (bus.rdata_valid_in | w_tmo) w_state_next = S_RESP;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request context and memory-side command registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt                <= 5'd0;
      r_write                  <= 1'b0;
      r_unsigned               <= 1'b0;
      r_size                   <= 2'b00;
      r_lane                   <= 2'b00;
      r_err                    <= 1'b0;
      r_rdata                  <= 32'h0;
      bus.mc_addr_out          <= 32'h0;
      bus.mc_write_data_out    <= 32'h0;
      bus.mc_write_byte_en_out <= 4'h0;
      bus.cs_out               <= 1'b0;
      bus.valid_out            <= 1'b0;
      bus.mc_read_en_out       <= 1'b0;
      bus.mc_write_en_out      <= 1'b0;
      bus.req_ready_out        <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_tmo_cnt <= 5'd0;
      else if ((r_state == S_REQ) | (r_state == S_RDATA))
        r_tmo_cnt <= r_tmo_cnt + 5'd1;

      if (w_accept) begin
        r_write    <= bus.req_write_in;
        r_unsigned <= bus.req_unsigned_in;
        r_size     <= bus.req_size_in;
        r_lane     <= bus.req_addr_in[1:0];
        r_err      <= w_misaligned;
        if (!w_misaligned) begin
          bus.mc_addr_out          <= {bus.req_addr_in[31:2], 2'b00};
          bus.mc_write_data_out    <= w_wdata;
          bus.mc_write_byte_en_out <= w_be;
          bus.cs_out               <= (bus.req_addr_in >= DATA_BASE);
        end
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end

      if (w_capture) r_rdata <= bus.mc_read_data_in;

      bus.valid_out       <= (w_state_next == S_REQ);
      bus.mc_read_en_out  <= (w_state_next == S_REQ) & ~(w_accept ? bus.req_write_in : r_write);
      bus.mc_write_en_out <= (w_state_next == S_REQ) &  (w_accept ? bus.req_write_in : r_write);
      bus.req_ready_out   <= (w_state_next == S_IDLE);
    end
  end

  // Response registers lag the RESP state by one cycle and hold between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.resp_valid_out <= 1'b0;
      bus.resp_err_out   <= 1'b0;
      bus.resp_data_out  <= 32'h0;
    end else begin
      bus.resp_valid_out <= (r_state == S_RESP);
      if (r_state == S_RESP) begin
        bus.resp_err_out  <= r_err;
        bus.resp_data_out <= (r_err | r_write) ? 32'h0 : w_load_ext;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
// ============================================================================
// Module      : tb_lsu_mem_master
// Description : Directed self-checking bench for lsu_mem_master.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_master;

  localparam int unsigned TMO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          t_lat;
  bit          t_saw_valid;
  bit          t_stable;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_be;
  logic        t_cs, t_rd, t_wr, t_err;

  lsu_mem_master_if bus();

  lsu_mem_master #(
    .DATA_BASE      (32'h8000_0000),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !bus.req_ready_out; i++) @(negedge clk);
    check("req_ready_wait", {31'h0, bus.req_ready_out}, 32'h1);
  endtask

  // Issues one request and plays the memory: ready after ready_delay valid
  // cycles; read data with the handshake (rdata_delay 0), N cycles later, or never (-1).
  task automatic transact(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input bit uns, input int ready_delay,
                          input int rdata_delay, input logic [31:0] rdata);
    int vcyc;
    int post;
    bit hs;
    vcyc = 0; post = 0; hs = 0;
    t_lat = -1; t_saw_valid = 0; t_stable = 1;
    wait_ready();
    bus.req_valid_in    = 1'b1;
    bus.req_write_in    = wr;
    bus.req_addr_in     = addr;
    bus.req_wdata_in    = wdata;
    bus.req_size_in     = size;
    bus.req_unsigned_in = uns;
    @(negedge clk);
    bus.req_valid_in = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      bus.ready_in       = 1'b0;
      bus.rdata_valid_in = 1'b0;
      if (bus.resp_valid_out) begin
        t_lat   = cyc;
        t_rdata = bus.resp_data_out;
        t_err   = bus.resp_err_out;
        break;
      end
      if (bus.valid_out) begin
        if (!t_saw_valid) begin
          t_addr  = bus.mc_addr_out;
          t_wdata = bus.mc_write_data_out;
          t_be    = bus.mc_write_byte_en_out;
          t_cs    = bus.cs_out;
          t_rd    = bus.mc_read_en_out;
          t_wr    = bus.mc_write_en_out;
        end else if (t_addr != bus.mc_addr_out || t_wdata != bus.mc_write_data_out ||
                     t_be != bus.mc_write_byte_en_out || t_cs != bus.cs_out ||
                     t_rd != bus.mc_read_en_out || t_wr != bus.mc_write_en_out) begin
          t_stable = 0;
        end
        t_saw_valid = 1;
        if (vcyc == ready_delay) begin
          bus.ready_in = 1'b1;
          hs = 1;
          if (rdata_delay == 0) begin
            bus.rdata_valid_in  = 1'b1;
            bus.mc_read_data_in = rdata;
          end
        end
        vcyc++;
      end else if (hs) begin
        post++;
        if (post == rdata_delay) begin
          bus.rdata_valid_in  = 1'b1;
          bus.mc_read_data_in = rdata;
        end
      end
      @(negedge clk);
    end
    bus.ready_in       = 1'b0;
    bus.rdata_valid_in = 1'b0;
    check("resp_seen", {31'h0, t_lat > 0}, 32'h1);
  endtask

  initial begin
    bit saw_resp;
    bus.req_valid_in    = 1'b0;
    bus.req_write_in    = 1'b0;
    bus.req_addr_in     = 32'h0;
    bus.req_wdata_in    = 32'h0;
    bus.req_size_in     = 2'b00;
    bus.req_unsigned_in = 1'b0;
    bus.ready_in        = 1'b0;
    bus.rdata_valid_in  = 1'b0;
    bus.mc_read_data_in = 32'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid",     {31'h0, bus.valid_out},      32'h0);
    check("rst_req_ready", {31'h0, bus.req_ready_out},  32'h0);
    check("rst_resp",      {31'h0, bus.resp_valid_out}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, bus.req_ready_out}, 32'h1);

    // Word load to data RAM, read data with the handshake.
    transact(1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0, 0, 0, 32'hDEAD_BEEF);
    check("lw_latency", t_lat,                 32'd3);
    check("lw_cs",      {31'h0, t_cs},         32'h1);
    check("lw_addr",    t_addr,                32'h8000_0010);
    check("lw_be",      {28'h0, t_be},         32'hF);
    check("lw_rd_en",   {30'h0, t_rd, t_wr},   32'h2);
    check("lw_data",    t_rdata,               32'hDEAD_BEEF);
    check("lw_err",     {31'h0, t_err},        32'h0);

    // Signed then unsigned byte load from lane 3 of instr RAM.
    transact(1'b0, 32'h0000_0103, 32'h0, 2'b00, 1'b0, 0, 0, 32'h80FF_FFFF);
    check("lb_be",   {28'h0, t_be},  32'h8);
    check("lb_cs",   {31'h0, t_cs},  32'h0);
    check("lb_addr", t_addr,         32'h0000_0100);
    check("lb_data", t_rdata,        32'hFFFF_FF80);
    transact(1'b0, 32'h0000_0103, 32'h0, 2'b00, 1'b1, 0, 0, 32'h80FF_FFFF);
    check("lbu_data", t_rdata, 32'h0000_0080);
    @(negedge clk);
    check("lbu_pulse", {31'h0, bus.resp_valid_out}, 32'h0);
    check("lbu_hold",  bus.resp_data_out,           32'h0000_0080);

    // Half store with three wait cycles.
    transact(1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'b01, 1'b0, 3, -1, 32'h0);
    check("sh_stable", {31'h0, t_stable},     32'h1);
    check("sh_wdata",  t_wdata,               32'hABCD_ABCD);
    check("sh_be",     {28'h0, t_be},         32'hC);
    check("sh_addr",   t_addr,                32'h8000_0000);
    check("sh_wr_en",  {30'h0, t_rd, t_wr},   32'h1);
    check("sh_latency", t_lat,                32'd6);
    check("sh_err",    {31'h0, t_err},        32'h0);
    check("sh_data",   t_rdata,               32'h0);
    @(negedge clk);
    check("sh_pulse", {31'h0, bus.resp_valid_out}, 32'h0);

    // Byte store replication.
    transact(1'b1, 32'h0000_0001, 32'h0000_00AA, 2'b00, 1'b0, 0, -1, 32'h0);
    check("sb_wdata", t_wdata,       32'hAAAA_AAAA);
    check("sb_be",    {28'h0, t_be}, 32'h2);

    // Half loads through the RDATA state.
    transact(1'b0, 32'h8000_0006, 32'h0, 2'b01, 1'b0, 1, 2, 32'h8123_4567);
    check("lh_be",   {28'h0, t_be}, 32'hC);
    check("lh_data", t_rdata,       32'hFFFF_8123);
    transact(1'b0, 32'h8000_0006, 32'h0, 2'b01, 1'b1, 0, 1, 32'h8123_4567);
    check("lhu_data", t_rdata, 32'h0000_8123);

    // Alignment and size errors: no memory request, response two cycles later.
    transact(1'b0, 32'h8000_0001, 32'h0, 2'b10, 1'b0, 0, 0, 32'h0);
    check("mis_w_valid", {31'h0, t_saw_valid}, 32'h0);
    check("mis_w_err",   {31'h0, t_err},       32'h1);
    check("mis_w_lat",   t_lat,                32'd2);
    check("mis_w_data",  t_rdata,              32'h0);
    transact(1'b0, 32'h8000_0003, 32'h0, 2'b01, 1'b0, 0, 0, 32'h0);
    check("mis_h_err",   {31'h0, t_err},       32'h1);
    transact(1'b1, 32'h0000_0000, 32'h0, 2'b11, 1'b0, 0, 0, 32'h0);
    check("size11_err",  {31'h0, t_err},       32'h1);
    check("size11_valid", {31'h0, t_saw_valid}, 32'h0);

    // Read data never returns.
    transact(1'b0, 32'h8000_0040, 32'h0, 2'b10, 1'b0, 0, -1, 32'h0);
    check("tmo_err",  {31'h0, t_err}, 32'h1);
    check("tmo_data", t_rdata,        32'h0);
    check("tmo_lat_range", {31'h0, (t_lat >= int'(TMO)) && (t_lat <= int'(TMO) + 3)}, 32'h1);

    // Reset while waiting in RDATA.
    wait_ready();
    bus.req_valid_in = 1'b1;
    bus.req_write_in = 1'b0;
    bus.req_addr_in  = 32'h8000_0020;
    bus.req_size_in  = 2'b10;
    @(negedge clk);
    bus.req_valid_in = 1'b0;
    bus.ready_in     = 1'b1;
    @(negedge clk);
    bus.ready_in = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",   {31'h0, bus.valid_out},      32'h0);
    check("arst_ready",   {31'h0, bus.req_ready_out},  32'h0);
    check("arst_addr",    bus.mc_addr_out,             32'h0);
    check("arst_cs",      {31'h0, bus.cs_out},         32'h0);
    check("arst_resp_err", {31'h0, bus.resp_err_out},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid_out) saw_resp = 1;
    end
    check("arst_no_resp", {31'h0, saw_resp},          32'h0);
    check("arst_ready_after", {31'h0, bus.req_ready_out}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
